multicycle_ctrl: RTL and testbench

Multicycle control sequencer for the MIPS datapath. It replaces the single-cycle decode-and-assert control with a state machine that walks each instruction through fetch, decode, execute, memory and writeback. It sits between the instruction register (opcode source) and the datapath muxes, register file and unified memory. Memory accesses are stretched by a `mem_ready` handshake, and retired instructions are counted.

---
 rtl/multicycle_if.sv | 37 +++
 rtl/multicycle_ctrl.sv | 178 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/multicycle_if.sv
// Datapath-facing bundle of the multicycle control sequencer: opcode/flag/handshake
// inputs, control strobes and debug/status outputs.
interface multicycle_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       IRWrite;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  opcode, zero, mem_ready,
    output IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
           RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           state, instr_done, illegal
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
           RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           state, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM with mem_ready stretching and retire counter.
// Define MULTICYCLE_ILLEGAL_TRAP_EN to trap unknown opcodes instead of NOP-ing them.
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  multicycle_if.master     bus,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB   = 4'd7,
    S_IEXEC  = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JUMP  = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ir_write_s, pc_write_s, pc_write_cond_s, mem_read_s, mem_write_s;
  logic reg_write_s, retire_s;

  // State, latched opcode and retire counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= 6'd0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and per-state control decode
  always_comb begin
    state_d         = state_q;
    ir_write_s      = 1'b0;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    reg_write_s     = 1'b0;
    retire_s        = 1'b0;
    bus.IorD        = 1'b0;
    bus.RegDst      = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = 2'b00;
    bus.PCSource    = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read_s  = 1'b1;
        bus.ALUSrcB = 2'b01;
        ir_write_s  = bus.mem_ready;
        pc_write_s  = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
        else               state_d = S_FETCH;
      end
      S_DECODE: begin
        bus.ALUSrcB = 2'b11;
        case (bus.opcode)
          6'b000000:            state_d = S_EXEC;
          6'b100011, 6'b101011: state_d = S_MEMADR;
          6'b001000, 6'b100111: state_d = S_IEXEC;
          6'b000100:            state_d = S_BRANCH;
          6'b000010:            state_d = S_JUMP;
          default: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            state_d = S_TRAP;
`else
            state_d  = S_FETCH;
            retire_s = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        if (op_q == 6'b100011) state_d = S_MEMRD;
        else                   state_d = S_MEMWR;
      end
      S_MEMRD: begin
        mem_read_s = 1'b1;
        bus.IorD   = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
        else               state_d = S_MEMRD;
      end
      S_MEMWB: begin
        reg_write_s  = 1'b1;
        bus.MemtoReg = 1'b1;
        retire_s     = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        mem_write_s = 1'b1;
        bus.IorD    = 1'b1;
        if (bus.mem_ready) begin
          retire_s = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d  = S_MEMWR;
        end
      end
      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
        state_d     = S_RWB;
      end
      S_RWB: begin
        reg_write_s = 1'b1;
        bus.RegDst  = 1'b1;
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_IEXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = S_IWB;
      end
      S_IWB: begin
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        pc_write_cond_s = 1'b1;
        bus.PCSource    = 2'b01;
        retire_s        = 1'b1;
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        pc_write_s   = 1'b1;
        bus.PCSource = 2'b10;
        retire_s     = 1'b1;
        state_d      = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  assign op_d  = (state_q == S_DECODE) ? bus.opcode : op_q;
  assign cnt_d = retire_s ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;

  // Strobes are suppressed while reset is asserted so an aborted instruction never writes
  assign bus.IRWrite     = ir_write_s      & rst_n;
  assign bus.PCWrite     = pc_write_s      & rst_n;
  assign bus.PCWriteCond = pc_write_cond_s & rst_n;
  assign bus.MemRead     = mem_read_s      & rst_n;
  assign bus.MemWrite    = mem_write_s     & rst_n;
  assign bus.RegWrite    = reg_write_s     & rst_n;
  assign bus.instr_done  = retire_s        & rst_n;
  assign bus.state       = state_q;
  assign instr_count     = cnt_q;

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky illegal flag, set on entry to TRAP
  always_ff @(posedge clk) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_q | (state_d == S_TRAP);
  end

  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (default and trap builds).
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst_n_w;
  logic [15:0] cnt;
  logic [3:0]  cnt_w;
  int          n_chk = 0;
  int          n_fail = 0;

  multicycle_if bus_m ();
  multicycle_if bus_w ();

  multicycle_ctrl #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_m), .instr_count(cnt)
  );
  multicycle_ctrl #(.CNT_W(4)) u_wrap (
    .clk(clk), .rst_n(rst_n_w), .bus(bus_w), .instr_count(cnt_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rst_n_w = 1'b0;
    bus_m.opcode = 6'b000000; bus_m.zero = 1'b0; bus_m.mem_ready = 1'b1;
    bus_w.opcode = 6'b000010; bus_w.zero = 1'b0; bus_w.mem_ready = 1'b1;
    step(); step();
    // reset state and strobe suppression
    chk("rst_state", bus_m.state, 0);
    chk("rst_count", cnt, 0);
    chk("rst_memread", bus_m.MemRead, 0);
    chk("rst_irwrite", bus_m.IRWrite, 0);
    chk("rst_done", bus_m.instr_done, 0);
    chk("rst_illegal", bus_m.illegal, 0);
    rst_n = 1'b1; #1;
    chk("fetch_memread", bus_m.MemRead, 1);
    chk("fetch_irwrite", bus_m.IRWrite, 1);
    chk("fetch_pcwrite", bus_m.PCWrite, 1);
    chk("fetch_srcb", bus_m.ALUSrcB, 2'b01);

    // R-type: 0,1,6,7
    step(); chk("r_decode", bus_m.state, 1); chk("r_dec_srcb", bus_m.ALUSrcB, 2'b11);
    step(); chk("r_exec", bus_m.state, 6); chk("r_aluop", bus_m.ALUOp, 2'b10);
    chk("r_exec_srca", bus_m.ALUSrcA, 1);
    step(); chk("r_rwb", bus_m.state, 7); chk("r_regwrite", bus_m.RegWrite, 1);
    chk("r_regdst", bus_m.RegDst, 1); chk("r_done", bus_m.instr_done, 1);
    step(); chk("r_fetch", bus_m.state, 0); chk("r_count", cnt, 1);
    chk("r_done_clr", bus_m.instr_done, 0);

    // lw with two wait cycles in MEMRD
    bus_m.opcode = 6'b100011;
    step(); chk("lw_decode", bus_m.state, 1);
    step(); chk("lw_memadr", bus_m.state, 2); chk("lw_srcb", bus_m.ALUSrcB, 2'b10);
    step(); bus_m.mem_ready = 1'b0; #1;
    chk("lw_memrd", bus_m.state, 3); chk("lw_iord", bus_m.IorD, 1);
    chk("lw_memread", bus_m.MemRead, 1); chk("lw_wait_done", bus_m.instr_done, 0);
    chk("lw_rd_mtr", bus_m.MemtoReg, 0);
    step(); chk("lw_memrd2", bus_m.state, 3);
    step(); chk("lw_memrd3", bus_m.state, 3); bus_m.mem_ready = 1'b1;
    step(); chk("lw_memwb", bus_m.state, 4); chk("lw_mtr", bus_m.MemtoReg, 1);
    chk("lw_regwrite", bus_m.RegWrite, 1); chk("lw_regdst", bus_m.RegDst, 0);
    chk("lw_done", bus_m.instr_done, 1);
    step(); chk("lw_fetch", bus_m.state, 0); chk("lw_mtr_clr", bus_m.MemtoReg, 0);
    chk("lw_count", cnt, 2);

    // beq taken and not taken: controls identical
    bus_m.opcode = 6'b000100; bus_m.zero = 1'b1;
    step(); step();
    chk("beq1_state", bus_m.state, 10); chk("beq1_pwc", bus_m.PCWriteCond, 1);
    chk("beq1_psrc", bus_m.PCSource, 2'b01); chk("beq1_pcw", bus_m.PCWrite, 0);
    chk("beq1_aluop", bus_m.ALUOp, 2'b01);
    step(); bus_m.zero = 1'b0;
    step(); step();
    chk("beq0_state", bus_m.state, 10); chk("beq0_pwc", bus_m.PCWriteCond, 1);
    chk("beq0_psrc", bus_m.PCSource, 2'b01); chk("beq0_pcw", bus_m.PCWrite, 0);
    step(); chk("beq_count", cnt, 4);

    // sw then j
    bus_m.opcode = 6'b101011;
    step(); step(); chk("sw_memadr", bus_m.state, 2);
    step(); chk("sw_memwr", bus_m.state, 5); chk("sw_memwrite", bus_m.MemWrite, 1);
    chk("sw_done", bus_m.instr_done, 1);
    step(); chk("sw_fetch", bus_m.state, 0); chk("sw_memwrite_clr", bus_m.MemWrite, 0);
    bus_m.opcode = 6'b000010;
    step(); chk("j_decode", bus_m.state, 1);
    step(); chk("j_state", bus_m.state, 11); chk("j_pcw", bus_m.PCWrite, 1);
    chk("j_psrc", bus_m.PCSource, 2'b10); chk("j_pwc", bus_m.PCWriteCond, 0);
    step(); chk("swj_count", cnt, 6);

    // reset while MEMWR waits on memory
    bus_m.opcode = 6'b101011;
    step(); step(); step(); bus_m.mem_ready = 1'b0; #1;
    chk("abort_memwr", bus_m.state, 5); chk("abort_mw_pre", bus_m.MemWrite, 1);
    chk("abort_wait_done", bus_m.instr_done, 0);
    rst_n = 1'b0; #1;
    chk("abort_mw_rst", bus_m.MemWrite, 0); chk("abort_done", bus_m.instr_done, 0);
    step(); chk("abort_state", bus_m.state, 0); chk("abort_count", cnt, 0);
    rst_n = 1'b1; bus_m.mem_ready = 1'b1;

    // unknown opcode
    bus_m.opcode = 6'b111111;
    step(); chk("ill_decode", bus_m.state, 1);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    chk("ill_done", bus_m.instr_done, 0);
    step(); chk("ill_trap", bus_m.state, 12); chk("ill_flag", bus_m.illegal, 1);
    for (int i = 0; i < 10; i++) step();
    chk("ill_trap_hold", bus_m.state, 12); chk("ill_flag_hold", bus_m.illegal, 1);
    chk("ill_count", cnt, 0);
`else
    chk("ill_done", bus_m.instr_done, 1);
    step(); chk("ill_fetch", bus_m.state, 0); chk("ill_flag", bus_m.illegal, 0);
    chk("ill_count", cnt, 1);
`endif

    // 4-bit counter wrap using back-to-back jumps
    rst_n_w = 1'b1;
    for (int i = 0; i < 45; i++) step();
    chk("wrap_pre_state", bus_w.state, 0); chk("wrap_pre", cnt_w, 15);
    step(); step(); chk("wrap_jump_done", bus_w.instr_done, 1);
    step(); chk("wrap_zero", cnt_w, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
